lsu_trigger_commit: RTL and testbench

- Downstream of the LSU trigger matcher; consumes the per-trigger dc3 match vector.
- Pipelines the matches through dc4/dc5 and applies chaining of trigger pairs plus flush/freeze qualification.
- At dc5 commit, records sticky hit bits and raises a debug-halt request or a breakpoint pulse toward dec/TLU.
- A small FSM holds the halt request until the TLU acknowledges it.

---
 rtl/lsu_trigger_commit_pkg.sv | 17 +
 rtl/lsu_trigger_commit_if.sv | 61 ++++++
 rtl/lsu_trigger_commit_chain.sv | 26 ++
 rtl/lsu_trigger_commit.sv | 99 +++++++++
 tb/tb_lsu_trigger_commit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_trigger_commit_pkg.sv
// LSU trigger commit: shared types and constants.
// Also reusable by the instruction-trigger path.
package lsu_trigger_commit_pkg;

    localparam int LSU_NUM_TRIG = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HALT = 1'b1
    } trig_fsm_e;

    typedef struct packed {
        logic                    valid;
        logic [LSU_NUM_TRIG-1:0] match;
    } trig_stage_t;

endpackage

// File: rtl/lsu_trigger_commit_if.sv
// LSU trigger commit: bundle between the LSU/TLU side
// and the commit block (master drives, slave is the block).
interface lsu_trigger_commit_if
    import lsu_trigger_commit_pkg::*;
#(
    parameter int NUM_TRIG = LSU_NUM_TRIG
) ();

    logic [NUM_TRIG-1:0]   lsu_trigger_match_dc3;
    logic                  lsu_pkt_valid_dc3;
    logic                  lsu_freeze_dc3;
    logic                  dec_tlu_flush_lower_wb;
    logic                  lsu_error_dc4;
    logic [NUM_TRIG/2-1:0] trigger_chain;
    logic [NUM_TRIG-1:0]   trigger_action;
    logic                  dec_tlu_trigger_en;
    logic [NUM_TRIG-1:0]   dec_tlu_mhit_clr;
    logic                  dec_tlu_halt_ack;
    logic [NUM_TRIG-1:0]   lsu_trigger_match_dc4;
    logic [NUM_TRIG-1:0]   lsu_trigger_match_dc5;
    logic [NUM_TRIG-1:0]   lsu_trigger_hit;
    logic                  lsu_trigger_bkpt_dc5;
    logic                  lsu_trigger_halt_req;

    modport master (
        output lsu_trigger_match_dc3,
        output lsu_pkt_valid_dc3,
        output lsu_freeze_dc3,
        output dec_tlu_flush_lower_wb,
        output lsu_error_dc4,
        output trigger_chain,
        output trigger_action,
        output dec_tlu_trigger_en,
        output dec_tlu_mhit_clr,
        output dec_tlu_halt_ack,
        input  lsu_trigger_match_dc4,
        input  lsu_trigger_match_dc5,
        input  lsu_trigger_hit,
        input  lsu_trigger_bkpt_dc5,
        input  lsu_trigger_halt_req
    );

    modport slave (
        input  lsu_trigger_match_dc3,
        input  lsu_pkt_valid_dc3,
        input  lsu_freeze_dc3,
        input  dec_tlu_flush_lower_wb,
        input  lsu_error_dc4,
        input  trigger_chain,
        input  trigger_action,
        input  dec_tlu_trigger_en,
        input  dec_tlu_mhit_clr,
        input  dec_tlu_halt_ack,
        output lsu_trigger_match_dc4,
        output lsu_trigger_match_dc5,
        output lsu_trigger_hit,
        output lsu_trigger_bkpt_dc5,
        output lsu_trigger_halt_req
    );

endinterface

// File: rtl/lsu_trigger_commit_chain.sv
// Pair chaining and qualification of a raw trigger match vector.
// Chained pair (2k,2k+1) survives only when both halves match.
module lsu_trigger_chain
    import lsu_trigger_commit_pkg::*;
#(
    parameter int NUM_TRIG = LSU_NUM_TRIG
) (
    input  logic [NUM_TRIG-1:0]   match_i,
    input  logic [NUM_TRIG/2-1:0] chain_i,
    input  logic                  valid_i,
    input  logic                  en_i,
    output logic [NUM_TRIG-1:0]   match_o
);

    logic [NUM_TRIG-1:0] chained;

    for (genvar k = 0; k < NUM_TRIG/2; k++) begin : g_pair
        logic both;
        assign both             = match_i[2*k] & match_i[2*k+1];
        assign chained[2*k]     = chain_i[k] ? both : match_i[2*k];
        assign chained[2*k+1]   = chain_i[k] ? both : match_i[2*k+1];
    end

    assign match_o = chained & {NUM_TRIG{valid_i & en_i}};

endmodule

// File: rtl/lsu_trigger_commit.sv
// LSU trigger commit: dc4/dc5 staging, sticky hits,
// breakpoint pulse and held debug-halt request.
module lsu_trigger_commit
    import lsu_trigger_commit_pkg::*;
#(
    parameter int NUM_TRIG = LSU_NUM_TRIG
) (
    input logic                clk,
    input logic                rst_l,
    lsu_trigger_commit_if.slave bus
);

    logic [NUM_TRIG-1:0] match_qual_dc3;
    logic [NUM_TRIG-1:0] dc4_q, dc4_d;
    logic [NUM_TRIG-1:0] dc5_q, dc5_d;
    logic [NUM_TRIG-1:0] hit_q, hit_d;
    logic [NUM_TRIG-1:0] commit_bits;
    logic                commit;
    logic                halt_any;
    logic                bkpt_any;
    logic                bkpt;
    trig_fsm_e           state_q, state_d;

    lsu_trigger_chain #(
        .NUM_TRIG (NUM_TRIG)
    ) u_chain (
        .match_i (bus.lsu_trigger_match_dc3),
        .chain_i (bus.trigger_chain),
        .valid_i (bus.lsu_pkt_valid_dc3),
        .en_i    (bus.dec_tlu_trigger_en),
        .match_o (match_qual_dc3)
    );

    // Stage advance: flush clears, freeze holds, else shift.
    always_comb begin
        dc4_d = dc4_q;
        dc5_d = dc5_q;
        if (bus.dec_tlu_flush_lower_wb) begin
            dc4_d = '0;
            dc5_d = '0;
        end else if (!bus.lsu_freeze_dc3) begin
            dc4_d = match_qual_dc3;
            dc5_d = dc4_q & ~{NUM_TRIG{bus.lsu_error_dc4}};
        end
    end

    // Commit qualification, action split and sticky-hit update.
    always_comb begin
        commit      = (|dc5_q) & ~bus.dec_tlu_flush_lower_wb
                    & ~bus.lsu_freeze_dc3;
        commit_bits = dc5_q & {NUM_TRIG{commit}};
        halt_any    = |(commit_bits & bus.trigger_action);
        bkpt_any    = |(commit_bits & ~bus.trigger_action);
        hit_d       = (hit_q & ~bus.dec_tlu_mhit_clr) | commit_bits;
    end

    // Halt FSM; an outstanding halt masks further bkpt/halt events.
    always_comb begin
        state_d = state_q;
        bkpt    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (halt_any) begin
                    state_d = HALT;
                end else begin
                    bkpt = bkpt_any;
                end
            end
            HALT: begin
                if (bus.dec_tlu_halt_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dc4_q   <= '0;
            dc5_q   <= '0;
            hit_q   <= '0;
            state_q <= IDLE;
        end else begin
            dc4_q   <= dc4_d;
            dc5_q   <= dc5_d;
            hit_q   <= hit_d;
            state_q <= state_d;
        end
    end

    assign bus.lsu_trigger_match_dc4 = dc4_q;
    assign bus.lsu_trigger_match_dc5 = dc5_q;
    assign bus.lsu_trigger_hit       = hit_q;
    assign bus.lsu_trigger_bkpt_dc5  = bkpt;
    assign bus.lsu_trigger_halt_req  = (state_q == HALT);

endmodule

// File: tb/tb_lsu_trigger_commit.sv
// Bench for lsu_trigger_commit: op-queue reference model,
// per-cycle expectations scored by a separate monitor.
module tb_lsu_trigger_commit;
    import lsu_trigger_commit_pkg::*;

    localparam int N = LSU_NUM_TRIG;

    typedef struct {
        logic [N-1:0]   m;
        logic           v;
        logic           frz;
        logic           fl;
        logic           err;
        logic [N/2-1:0] ch;
        logic [N-1:0]   act;
        logic           en;
        logic [N-1:0]   clr;
        logic           ack;
    } stim_t;

    typedef struct {
        logic [N-1:0] dc4;
        logic [N-1:0] dc5;
        logic [N-1:0] hit;
        logic         bkpt;
        logic         halt;
    } exp_t;

    typedef struct {
        logic [N-1:0] m;
        int           stage;
    } op_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    lsu_trigger_commit_if #(.NUM_TRIG(N)) bus ();

    lsu_trigger_commit #(.NUM_TRIG(N)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    int   vectors = 0;
    int   miscompares = 0;
    exp_t expq[$];
    op_t  pipe[$];
    logic [N-1:0] m_hit = '0;
    bit   m_halting = 0;

    task automatic check(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b, expected %b",
                     name, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] chain_fn(input logic [N-1:0] m,
                                              input logic [N/2-1:0] ch);
        logic [N-1:0] r;
        r = m;
        for (int k = 0; k < N/2; k++) begin
            if (ch[k] && !(m[2*k] && m[2*k+1])) begin
                r[2*k]   = 1'b0;
                r[2*k+1] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.m = '0; s.v = 1'b0; s.frz = 1'b0; s.fl = 1'b0;
        s.err = 1'b0; s.ch = '0; s.act = '0; s.en = 1'b1;
        s.clr = '0; s.ack = 1'b0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.lsu_trigger_match_dc3  = s.m;
        bus.lsu_pkt_valid_dc3      = s.v;
        bus.lsu_freeze_dc3         = s.frz;
        bus.dec_tlu_flush_lower_wb = s.fl;
        bus.lsu_error_dc4          = s.err;
        bus.trigger_chain          = s.ch;
        bus.trigger_action         = s.act;
        bus.dec_tlu_trigger_en     = s.en;
        bus.dec_tlu_mhit_clr       = s.clr;
        bus.dec_tlu_halt_ack       = s.ack;
    endtask

    // One cycle: drive, predict this cycle's outputs, advance model.
    task automatic drive(input stim_t s);
        logic [N-1:0] e4, e5, cb;
        bit commit, h, b;
        exp_t e;
        op_t nq[$];
        @(posedge clk);
        #1;
        apply(s);
        e4 = '0;
        e5 = '0;
        foreach (pipe[i]) begin
            if (pipe[i].stage == 4) e4 = pipe[i].m;
            else e5 = pipe[i].m;
        end
        commit = (e5 != '0) && !s.fl && !s.frz;
        cb = commit ? e5 : '0;
        h = |(cb & s.act);
        b = |(cb & ~s.act);
        e.dc4 = e4;
        e.dc5 = e5;
        e.hit = m_hit;
        e.bkpt = b && !h && !m_halting;
        e.halt = m_halting;
        expq.push_back(e);
        m_hit = (m_hit & ~s.clr) | cb;
        if (m_halting) begin
            if (s.ack) m_halting = 0;
        end else if (h) begin
            m_halting = 1;
        end
        if (s.fl) begin
            pipe.delete();
        end else if (!s.frz) begin
            foreach (pipe[i]) begin
                if (pipe[i].stage == 4)
                    nq.push_back('{m: pipe[i].m & ~{N{s.err}}, stage: 5});
            end
            nq.push_back('{m: chain_fn(s.m, s.ch) & {N{s.v && s.en}},
                           stage: 4});
            pipe = nq;
        end
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) drive(idle());
    endtask

    // Monitor: pop the expectation for this cycle and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("dc4", bus.lsu_trigger_match_dc4, e.dc4);
                check("dc5", bus.lsu_trigger_match_dc5, e.dc5);
                check("hit", bus.lsu_trigger_hit, e.hit);
                check("bkpt", N'(bus.lsu_trigger_bkpt_dc5), N'(e.bkpt));
                check("halt_req", N'(bus.lsu_trigger_halt_req), N'(e.halt));
            end
        end
    end

    initial begin
        stim_t s;
        apply(idle());
        @(negedge clk);
        check("rst_dc4", bus.lsu_trigger_match_dc4, '0);
        check("rst_dc5", bus.lsu_trigger_match_dc5, '0);
        check("rst_hit", bus.lsu_trigger_hit, '0);
        check("rst_halt", N'(bus.lsu_trigger_halt_req), '0);
        #1 rst_l = 1'b1;

        // single unchained breakpoint
        s = idle(); s.m = 4'b0001; s.v = 1; drive(s);
        idles(4);
        // chaining: lone half dropped, full pair passes
        s = idle(); s.ch = 2'b01; s.m = 4'b0001; s.v = 1; drive(s);
        s.m = 4'b0011; drive(s);
        idles(4);
        // halt with priority over bkpt, then ack
        s = idle(); s.m = 4'b0101; s.act = 4'b0100; s.v = 1; drive(s);
        s = idle(); s.act = 4'b0100;
        for (int i = 0; i < 5; i++) drive(s);
        s.ack = 1; drive(s);
        idles(3);
        // ack while idle
        s = idle(); s.ack = 1; drive(s);
        // flush mid-flight, then a normal match
        s = idle(); s.m = 4'b1000; s.v = 1; drive(s);
        s = idle(); s.fl = 1; s.m = 4'b0100; s.v = 1; drive(s);
        s = idle(); s.m = 4'b1000; s.v = 1; drive(s);
        idles(4);
        // freeze for three cycles
        s = idle(); s.m = 4'b0010; s.v = 1; drive(s);
        s = idle(); s.frz = 1; s.m = 4'b0001; s.v = 1;
        for (int i = 0; i < 3; i++) drive(s);
        idles(4);
        // access error in dc4
        s = idle(); s.m = 4'b0100; s.v = 1; drive(s);
        s = idle(); s.err = 1; drive(s);
        idles(3);
        // sticky set/clear collision
        s = idle(); s.clr = '1; drive(s);
        s = idle(); s.m = 4'b0001; s.v = 1; drive(s);
        idles(3);
        s = idle(); s.m = 4'b0010; s.v = 1; drive(s);
        idles(1);
        s = idle(); s.clr = 4'b0011; drive(s);
        idles(2);
        // trigger enable off
        s = idle(); s.m = 4'b1111; s.v = 1; s.en = 0; drive(s);
        idles(3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s.m   = N'($urandom);
            s.v   = ($urandom_range(0, 3) != 0);
            s.frz = ($urandom_range(0, 7) == 0);
            s.fl  = ($urandom_range(0, 15) == 0);
            s.err = ($urandom_range(0, 7) == 0);
            s.ch  = (N/2)'($urandom);
            s.act = N'($urandom);
            s.en  = ($urandom_range(0, 7) != 0);
            s.clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            s.ack = ($urandom_range(0, 3) == 0);
            drive(s);
        end

        // make sure something is sticky, then async reset between edges
        s = idle(); s.m = 4'b1001; s.v = 1; drive(s);
        idles(3);
        @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        check("arst_dc4", bus.lsu_trigger_match_dc4, '0);
        check("arst_dc5", bus.lsu_trigger_match_dc5, '0);
        check("arst_hit", bus.lsu_trigger_hit, '0);
        check("arst_bkpt", N'(bus.lsu_trigger_bkpt_dc5), '0);
        check("arst_halt", N'(bus.lsu_trigger_halt_req), '0);
        if (expq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: %0d expectations left, expected 0",
                     expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
